// File: rtl/addsub_pkg.sv
// addsub_pkg: shared op encodings, flag bundle and segment sizing
// for the pipelined add/sub unit (addsub_pipe) and its segment adder.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

  function automatic int seg_w(input int w, input int s);
    return w / s;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG-bit adder slice.
// Ports: i_a/i_b slice operands, i_c carry-in; o_s sum, o_c carry-out, o_z sum==0.
module addsub_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_c,
  output logic [SEG-1:0] o_s,
  output logic           o_c,
  output logic           o_z
);

  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_c};
  assign o_z        = (o_s == '0);

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: STAGES-deep segmented add/sub with valid/ready and flags.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, op (1=sub);
//   out_valid/out_ready, result, cout, ovf, zero, neg.
// Option: define ADDSUB_PIPE_SAT_EN to add input sat (clamp on overflow).
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam int L   = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  // Stage k registers: operands (skew), partial result, carry, zero-so-far
  logic  [STAGES-1:0] r_v, r_c, r_z;
  word_t [STAGES-1:0] r_a, r_b, r_r;
  logic               r_ovf;

  // Stage k inputs (w_*i) and outputs
  word_t [STAGES-1:0]          w_a, w_b, w_ri, w_ro;
  logic  [STAGES-1:0]          w_ci, w_zi, w_vi, w_co, w_zs;
  logic  [STAGES-1:0][SEG-1:0] w_s;

  word_t         w_fin;
  logic          w_ovf, w_zfin, w_clamp, w_stall;
  addsub_flags_t w_fl;

`ifdef ADDSUB_PIPE_SAT_EN
  logic [STAGES-1:0] r_s, w_si;
`endif

  assign w_stall  = r_v[L] & ~out_ready;
  assign in_ready = ~w_stall;

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_ri = '0;
    w_ci = '0;
    w_zi = '0;
    w_vi = '0;
    w_a[0]  = a;
    w_b[0]  = b ^ {WIDTH{op == OP_SUB}};
    w_ci[0] = op;
    w_zi[0] = 1'b1;
    w_vi[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k]  = r_a[k-1];
      w_b[k]  = r_b[k-1];
      w_ri[k] = r_r[k-1];
      w_ci[k] = r_c[k-1];
      w_zi[k] = r_z[k-1];
      w_vi[k] = r_v[k-1];
    end
  end

`ifdef ADDSUB_PIPE_SAT_EN
  always_comb begin
    w_si    = '0;
    w_si[0] = sat;
    for (int k = 1; k < STAGES; k++) begin
      w_si[k] = r_s[k-1];
    end
  end
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(
      .SEG(SEG)
    ) u_seg (
      .i_a(w_a[k][k*SEG +: SEG]),
      .i_b(w_b[k][k*SEG +: SEG]),
      .i_c(w_ci[k]),
      .o_s(w_s[k]),
      .o_c(w_co[k]),
      .o_z(w_zs[k])
    );
  end

  // Merge this stage's slice into the result carried so far
  always_comb begin
    w_ro = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_ro[k]                = w_ri[k];
      w_ro[k][k*SEG +: SEG] = w_s[k];
    end
  end

  // b is already conditionally inverted, so its MSB is b'_msb
  assign w_ovf = (w_a[L][WIDTH-1] == w_b[L][WIDTH-1]) &&
                 (w_ro[L][WIDTH-1] != w_a[L][WIDTH-1]);

`ifdef ADDSUB_PIPE_SAT_EN
  assign w_clamp = w_si[L] & w_ovf;
`else
  assign w_clamp = 1'b0;
`endif

  assign w_fin = !w_clamp ? w_ro[L] :
                 w_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};

  // A clamped value is never zero
  assign w_zfin = w_zi[L] & w_zs[L] & ~w_clamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_r   <= '0;
      r_c   <= '0;
      r_z   <= '0;
      r_ovf <= 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
      r_s   <= '0;
`endif
    end else if (!w_stall) begin
      r_v    <= w_vi;
      r_a    <= w_a;
      r_b    <= w_b;
      r_r    <= w_ro;
      r_c    <= w_co;
      r_z    <= w_zi & w_zs;
      r_r[L] <= w_fin;
      r_z[L] <= w_zfin;
      r_ovf  <= w_ovf;
`ifdef ADDSUB_PIPE_SAT_EN
      r_s    <= w_si;
`endif
    end
  end

  assign w_fl = '{cout: r_c[L], ovf: r_ovf,
                  zero: r_z[L], neg: r_r[L][WIDTH-1]};

  assign out_valid = r_v[L];
  assign result    = r_r[L];
  assign cout      = w_fl.cout;
  assign ovf       = w_fl.ovf;
  assign zero      = w_fl.zero;
  assign neg       = w_fl.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed vectors, backpressure, reset and random
// checks of addsub_pipe at 32/4, 8/1 and 64/8 against a reference model.
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic        iv[3], ordy[3], iop[3], isat[3];
  logic [63:0] ia[3], ib[3];
  logic        ov[3], ir[3], oc[3], oo[3], oz[3], onf[3];
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [63:0] res64;

  addsub_pipe #(.WIDTH(32), .STAGES(4)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ia[0][31:0]), .b(ib[0][31:0]), .op(iop[0]),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(isat[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res32),
    .cout(oc[0]), .ovf(oo[0]), .zero(oz[0]), .neg(onf[0])
  );

  addsub_pipe #(.WIDTH(8), .STAGES(1)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ia[1][7:0]), .b(ib[1][7:0]), .op(iop[1]),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(isat[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res8),
    .cout(oc[1]), .ovf(oo[1]), .zero(oz[1]), .neg(onf[1])
  );

  addsub_pipe #(.WIDTH(64), .STAGES(8)) u_d64 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(ia[2]), .b(ib[2]), .op(iop[2]),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(isat[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(res64),
    .cout(oc[2]), .ovf(oo[2]), .zero(oz[2]), .neg(onf[2])
  );

  typedef struct {
    logic [63:0] res;
    logic        c, v, z, n;
    int          t;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] a, b;
    logic        op, sat;
    logic [31:0] r;
    logic        c, v, z, n;
  } vec_t;

  function automatic int wid(input int d);
    return (d == 0) ? 32 : (d == 1) ? 8 : 64;
  endfunction

  function automatic int stg(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  function automatic logic [63:0] get_res(input int d);
    return (d == 0) ? {32'd0, res32} : (d == 1) ? {56'd0, res8} : res64;
  endfunction

  function automatic exp_t obs(input int d);
    exp_t e;
    e.res = get_res(d);
    e.c = oc[d]; e.v = oo[d]; e.z = oz[d]; e.n = onf[d];
    e.t = 0;
    return e;
  endfunction

  function automatic logic [127:0] pk(input exp_t e);
    return {60'd0, e.res, e.c, e.v, e.z, e.n};
  endfunction

  // Signed/unsigned arithmetic on wide integers, then reduce mod 2^w
  function automatic exp_t model(input int w, input logic [63:0] a_,
                                 input logic [63:0] b_, input logic op_,
                                 input logic sat_);
    exp_t e;
    logic signed [66:0] big, ua, ub, sa, sb, t, mx, mn, um;
    logic [63:0] mask;
    big  = 67'sd1 <<< w;
    mask = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    ua = $signed({3'b000, a_ & mask});
    ub = $signed({3'b000, b_ & mask});
    um = $signed({3'b000, mask});
    sa = a_[w-1] ? ua - big : ua;
    sb = b_[w-1] ? ub - big : ub;
    t  = op_ ? sa - sb : sa + sb;
    mx = (big >>> 1) - 67'sd1;
    mn = -(big >>> 1);
    e.v = (t > mx) || (t < mn);
    e.c = op_ ? (ua >= ub) : (ua + ub > um);
    if (sat_ && e.v) t = (t > mx) ? mx : mn;
    e.res = t[63:0] & mask;
    e.z = (e.res == 64'd0);
    e.n = e.res[w-1];
    e.t = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int d, input logic v, input logic [63:0] a_,
                     input logic [63:0] b_, input logic op_,
                     input logic s_, input logic r_);
    iv[d] = v; ia[d] = a_; ib[d] = b_;
    iop[d] = op_; isat[d] = s_; ordy[d] = r_;
  endtask

  task automatic run_vec(input vec_t vv);
    int   n = 0;
    exp_t e;
    e.res = {32'd0, vv.r};
    e.c = vv.c; e.v = vv.v; e.z = vv.z; e.n = vv.n; e.t = 0;
    @(posedge clk); #1;
    drv(0, 1'b1, {32'd0, vv.a}, {32'd0, vv.b}, vv.op, vv.sat, 1'b1);
    do begin
      @(posedge clk); #1;
      iv[0] = 1'b0;
      n++;
    end while (!ov[0] && n < 20);
    chk({vv.nm, " latency"}, n, 4);
    chk(vv.nm, pk(obs(0)), pk(e));
  endtask

  // mode 0: random valid, ready held high (fixed latency checked)
  // mode 1: random valid and ready
  // mode 2: a=b=i adds with out_ready low for cycles 5..9
  task automatic stream(input int d, input int mode, input int n);
    exp_t        q[$];
    exp_t        e;
    int          pushed = 0;
    int          it = 0;
    int          w = wid(d);
    int          lim = n * 4 + 200;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_res = '0;
    logic [63:0] mask, a_, b_;
    logic        v_, r_, op_, s_;
    mask = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    while ((pushed < n || q.size() > 0) && it < lim) begin
      @(posedge clk); #1;
      if (prev_stall)
        chk($sformatf("d%0d hold", d), {ov[d], get_res(d)},
            {1'b1, prev_res});
      a_  = {$urandom, $urandom} & mask;
      b_  = {$urandom, $urandom} & mask;
      op_ = 1'($urandom_range(0, 1));
      s_  = 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
      s_  = ($urandom_range(0, 3) == 0);
`endif
      case ($urandom_range(0, 7))
        0: b_ = a_;
        1: a_ = mask;
        2: b_ = mask;
        default: ;
      endcase
      v_ = (pushed < n);
      r_ = 1'b1;
      if (mode == 0) begin
        v_ = v_ && ($urandom_range(0, 3) != 0);
      end else if (mode == 1) begin
        v_ = v_ && ($urandom_range(0, 1) != 0);
        r_ = ($urandom_range(0, 2) != 0);
      end else begin
        a_ = 64'(pushed); b_ = 64'(pushed); op_ = 1'b0; s_ = 1'b0;
        r_ = !(it >= 5 && it <= 9);
      end
      drv(d, v_, a_, b_, op_, s_, r_);
      #1;
      chk($sformatf("d%0d in_ready", d), ir[d], !(ov[d] && !r_));
      if (ov[d] && r_) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL d%0d dup: got output %0h expected none",
                   d, get_res(d));
        end else begin
          e = q.pop_front();
          chk($sformatf("d%0d result", d), pk(obs(d)), pk(e));
          if (mode == 0)
            chk($sformatf("d%0d latency", d), it - e.t, stg(d));
        end
      end
      if (v_ && ir[d]) begin
        e   = model(w, a_, b_, op_, s_);
        e.t = it;
        q.push_back(e);
        pushed++;
      end
      prev_stall = ov[d] && !r_;
      prev_res   = get_res(d);
      it++;
    end
    iv[d] = 1'b0;
    chk($sformatf("d%0d drained", d), q.size() + (n - pushed), 0);
  endtask

  initial begin
    vec_t vt[$];
    int   n;
    vt.push_back('{"add", 32'h5, 32'h3, 1'b0, 1'b0,
                   32'h8, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{"sub borrow", 32'h0, 32'h1, 1'b1, 1'b0,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{"sub eq", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0,
                   32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    vt.push_back('{"add ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
                   32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    vt.push_back('{"add wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
                   32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    vt.push_back('{"sub ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0,
                   32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{"sub neg", 32'h3, 32'h5, 1'b1, 1'b0,
                   32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef ADDSUB_PIPE_SAT_EN
    vt.push_back('{"sat pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1,
                   32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{"sat neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1,
                   32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1});
`endif

    for (int d = 0; d < 3; d++) drv(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset valid", d), ov[d], 1'b0);
      chk($sformatf("d%0d reset outs", d), pk(obs(d)), '0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d reset in_ready", d), ir[d], 1'b1);

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);

    stream(0, 0, 300);
    stream(0, 1, 300);
    stream(0, 2, 8);

    // Reset with three ops in flight and the output stalled
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b1, 64'(i + 1), 64'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre-reset valid", ov[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset valid", ov[0], 1'b0);
    chk("async reset outs", pk(obs(0)), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post reset in_ready", ir[0], 1'b1);
    run_vec('{"post reset", 32'h9, 32'h1, 1'b0, 1'b0,
              32'hA, 1'b0, 1'b0, 1'b0, 1'b0});
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov[0]) n++;
    end
    chk("post reset idle", n, 0);

    stream(1, 0, 1000);
    stream(1, 1, 200);
    stream(2, 0, 1000);
    stream(2, 1, 200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
